fila_driver: RTL and testbench

//  Producer/consumer front end for the 8-entry byte queue (fila). Turns raw enqueue/dequeue

---
 rtl/fila_pkg.sv | 20 ++
 rtl/fila_driver_if.sv | 16 +
 rtl/btn_debounce.sv | 48 ++++
 rtl/fila_driver.sv | 102 ++++++++++
 tb/tb_fila_driver.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fila_pkg.sv
// Shared types and constants for the fila queue front end.
package fila_pkg;
  localparam int DEPTH_DEFAULT = 8;
  localparam int LEN_W         = 4;
  localparam int DATA_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENQ     = 3'd1,
    ST_DEQ     = 3'd2,
    ST_SETTLE1 = 3'd3,
    ST_SETTLE2 = 3'd4
  } drv_state_t;

  // Clamp a reported length so a glitching queue can never wrap the display.
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] v,
                                               input logic [LEN_W-1:0] cap);
    return (v > cap) ? cap : v;
  endfunction
endpackage

// File: rtl/fila_driver_if.sv
// Driver <-> queue link: strobes and data toward the queue, registered data/length back.
// Strobes are single-cycle, never both high, and carry no ready; the queue must accept or ignore them.
interface fila_driver_if;
  import fila_pkg::*;

  logic              enqueue_out;
  logic              dequeue_out;
  logic [DATA_W-1:0] data_to_q;
  logic [DATA_W-1:0] q_data;
  logic [LEN_W-1:0]  q_len;

  modport master (output enqueue_out, dequeue_out, data_to_q,
                  input  q_data, q_len);
  modport slave  (input  enqueue_out, dequeue_out, data_to_q,
                  output q_data, q_len);
endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, level debouncer, rising-edge press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 200
) (
  input  logic clk_10KHz,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);
  localparam int CNT_W = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the accepted level; flip after DEBOUNCE_CYC.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign press_o = level_q & ~level_prev_q;
endmodule

// File: rtl/fila_driver.sv
// Front end for the 8-entry byte queue: buttons -> single-cycle strobes, captures the
// queue's lagging length/data outputs, and drives display values and status flags.
module fila_driver
  import fila_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEFAULT,
  parameter int DEBOUNCE_CYC = 200
) (
  input  logic              clk_10KHz,
  input  logic              reset,
  input  logic              btn_enq,
  input  logic              btn_deq,
  input  logic [DATA_W-1:0] sw_data,
  fila_driver_if.master     q_if,
  output logic [DATA_W-1:0] shown_data,
  output logic [LEN_W-1:0]  shown_len,
  output logic              full,
  output logic              empty,
  output logic              err,
  output drv_state_t        dbg_state
);
  logic enq_press, deq_press;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_enq_db (
    .clk_10KHz (clk_10KHz),
    .reset     (reset),
    .btn_i     (btn_enq),
    .press_o   (enq_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deq_db (
    .clk_10KHz (clk_10KHz),
    .reset     (reset),
    .btn_i     (btn_deq),
    .press_o   (deq_press)
  );

  drv_state_t        state_q;
  logic              enq_q, deq_q, op_deq_q, err_q;
  logic [DATA_W-1:0] data_to_q_q, shown_data_q;
  logic [LEN_W-1:0]  shown_len_q;

  assign full  = (shown_len_q == LEN_W'(DEPTH));
  assign empty = (shown_len_q == '0);

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      enq_q        <= 1'b0;
      deq_q        <= 1'b0;
      op_deq_q     <= 1'b0;
      err_q        <= 1'b0;
      data_to_q_q  <= '0;
      shown_data_q <= '0;
      shown_len_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Enqueue has priority, matching the queue; a simultaneous dequeue press is dropped.
          if (enq_press && !full) begin
            data_to_q_q <= sw_data;
            enq_q       <= 1'b1;
            op_deq_q    <= 1'b0;
            state_q     <= ST_ENQ;
          end else if (deq_press && !empty) begin
            deq_q    <= 1'b1;
            op_deq_q <= 1'b1;
            state_q  <= ST_DEQ;
          end else if (enq_press || deq_press) begin
            err_q <= 1'b1;
          end
        end
        ST_ENQ, ST_DEQ: begin
          enq_q   <= 1'b0;
          deq_q   <= 1'b0;
          state_q <= ST_SETTLE1;
        end
        ST_SETTLE1: state_q <= ST_SETTLE2;
        ST_SETTLE2: begin
          // q_len lags occupancy by a cycle, so it is valid only here.
          shown_len_q <= sat_len(q_if.q_len, LEN_W'(DEPTH));
          if (op_deq_q) shown_data_q <= q_if.q_data;
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          enq_q   <= 1'b0;
          deq_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign q_if.enqueue_out = enq_q;
  assign q_if.dequeue_out = deq_q;
  assign q_if.data_to_q   = data_to_q_q;
  assign shown_data       = shown_data_q;
  assign shown_len        = shown_len_q;
  assign err              = err_q;
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_fila_driver.sv
// Directed bench for fila_driver driving a small behavioural model of the 8-entry queue.
module tb_fila_driver;
  import fila_pkg::*;

  localparam int DEB = 4;

  logic       clk_10KHz = 1'b0;
  logic       reset     = 1'b1;
  logic       btn_enq   = 1'b0;
  logic       btn_deq   = 1'b0;
  logic [7:0] sw_data   = 8'h00;
  logic [7:0] shown_data;
  logic [3:0] shown_len;
  logic       full, empty, err;
  drv_state_t dbg_state;

  int tests = 0;
  int fails = 0;
  int enq_seen = 0, deq_seen = 0, both_seen = 0;
  int e0, d0;

  fila_driver_if q_if ();

  fila_driver #(.DEPTH(8), .DEBOUNCE_CYC(DEB)) dut (
    .clk_10KHz  (clk_10KHz),
    .reset      (reset),
    .btn_enq    (btn_enq),
    .btn_deq    (btn_deq),
    .sw_data    (sw_data),
    .q_if       (q_if.master),
    .shown_data (shown_data),
    .shown_len  (shown_len),
    .full       (full),
    .empty      (empty),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  always #5 clk_10KHz = ~clk_10KHz;

  // Queue model: registered data_out, len_out lagging occupancy by one cycle, enqueue priority.
  logic [7:0] mem [8];
  logic [2:0] head_q, tail_q;
  logic [3:0] occ_q;
  always @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      q_if.q_len  <= '0;
      q_if.q_data <= '0;
    end else begin
      q_if.q_len <= occ_q;
      if (q_if.enqueue_out && occ_q < 4'd8) begin
        mem[tail_q] <= q_if.data_to_q;
        tail_q      <= tail_q + 3'd1;
        occ_q       <= occ_q + 4'd1;
      end else if (q_if.dequeue_out && occ_q > 4'd0) begin
        q_if.q_data <= mem[head_q];
        head_q      <= head_q + 3'd1;
        occ_q       <= occ_q - 4'd1;
      end
    end
  end

  always @(negedge clk_10KHz) begin
    if (q_if.enqueue_out) enq_seen++;
    if (q_if.dequeue_out) deq_seen++;
    if (q_if.enqueue_out && q_if.dequeue_out) both_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic do_press(input bit enq, input bit deq, input logic [7:0] val, input int hold);
    @(negedge clk_10KHz);
    sw_data = val;
    btn_enq = enq;
    btn_deq = deq;
    repeat (hold) @(negedge clk_10KHz);
    btn_enq = 1'b0;
    btn_deq = 1'b0;
    repeat (16) @(negedge clk_10KHz);
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk_10KHz);
    reset = 1'b0;
    repeat (2) @(negedge clk_10KHz);
    check("rst_len", 32'(shown_len), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_enq_strobe", 32'(q_if.enqueue_out), 32'd0);
    check("rst_deq_strobe", 32'(q_if.dequeue_out), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Enqueue 0xA5 then dequeue it
    e0 = enq_seen;
    do_press(1'b1, 1'b0, 8'hA5, 14);
    check("a5_enq_pulses", 32'(enq_seen - e0), 32'd1);
    check("a5_len1", 32'(shown_len), 32'd1);
    check("a5_data_to_q", 32'(q_if.data_to_q), 32'hA5);
    check("a5_not_empty", 32'(empty), 32'd0);
    d0 = deq_seen;
    do_press(1'b0, 1'b1, 8'h00, 14);
    check("a5_deq_pulses", 32'(deq_seen - d0), 32'd1);
    check("a5_len0", 32'(shown_len), 32'd0);
    check("a5_shown", 32'(shown_data), 32'hA5);
    check("a5_empty", 32'(empty), 32'd1);

    // Dequeue when empty is rejected
    d0 = deq_seen;
    do_press(1'b0, 1'b1, 8'h00, 14);
    check("empty_deq_err", 32'(err), 32'd1);
    check("empty_deq_no_strobe", 32'(deq_seen - d0), 32'd0);

    // Eight enqueues; the first valid one clears err
    do_press(1'b1, 1'b0, 8'h01, 14);
    check("err_cleared", 32'(err), 32'd0);
    check("len_after_first", 32'(shown_len), 32'd1);
    for (int v = 2; v <= 8; v++) do_press(1'b1, 1'b0, 8'(v), 14);
    check("full_len", 32'(shown_len), 32'd8);
    check("full_flag", 32'(full), 32'd1);

    // Ninth enqueue rejected
    e0 = enq_seen;
    do_press(1'b1, 1'b0, 8'h09, 14);
    check("ninth_err", 32'(err), 32'd1);
    check("ninth_no_strobe", 32'(enq_seen - e0), 32'd0);
    check("ninth_len", 32'(shown_len), 32'd8);

    // Dequeue five: FIFO order, err cleared
    do_press(1'b0, 1'b1, 8'h00, 14);
    check("deq1_data", 32'(shown_data), 32'h01);
    check("deq1_err_clr", 32'(err), 32'd0);
    check("deq1_len", 32'(shown_len), 32'd7);
    for (int k = 0; k < 4; k++) do_press(1'b0, 1'b1, 8'h00, 14);
    check("deq5_data", 32'(shown_data), 32'h05);
    check("deq5_len", 32'(shown_len), 32'd3);

    // Both buttons together at len=3: enqueue wins
    e0 = enq_seen;
    d0 = deq_seen;
    do_press(1'b1, 1'b1, 8'h3C, 14);
    check("both_enq", 32'(enq_seen - e0), 32'd1);
    check("both_no_deq", 32'(deq_seen - d0), 32'd0);
    check("both_len", 32'(shown_len), 32'd4);
    check("both_shown_kept", 32'(shown_data), 32'h05);

    // Bounce shorter than the debounce window
    e0 = enq_seen;
    for (int k = 0; k < 6; k++) begin
      btn_enq = 1'b1;
      repeat (2) @(negedge clk_10KHz);
      btn_enq = 1'b0;
      repeat (2) @(negedge clk_10KHz);
    end
    repeat (16) @(negedge clk_10KHz);
    check("bounce_no_strobe", 32'(enq_seen - e0), 32'd0);
    check("bounce_len", 32'(shown_len), 32'd4);

    // Held for 100 cycles gives one press
    e0 = enq_seen;
    do_press(1'b1, 1'b0, 8'h77, 100);
    check("held_one_strobe", 32'(enq_seen - e0), 32'd1);
    check("held_len", 32'(shown_len), 32'd5);

    // Reset during SETTLE1
    e0 = enq_seen;
    @(negedge clk_10KHz);
    sw_data = 8'h5A;
    btn_enq = 1'b1;
    for (int i = 0; i < 40 && dbg_state != ST_SETTLE1; i++) @(negedge clk_10KHz);
    check("reach_settle1", 32'(dbg_state), 32'(ST_SETTLE1));
    #1 reset = 1'b1;
    btn_enq = 1'b0;
    #1;
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("midrst_len", 32'(shown_len), 32'd0);
    check("midrst_data", 32'(shown_data), 32'h00);
    check("midrst_dtq", 32'(q_if.data_to_q), 32'h00);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_enq_strobe", 32'(q_if.enqueue_out), 32'd0);
    repeat (3) @(negedge clk_10KHz);
    reset = 1'b0;
    e0 = enq_seen;
    repeat (30) @(negedge clk_10KHz);
    check("postrst_no_strobe", 32'(enq_seen - e0), 32'd0);
    check("postrst_err", 32'(err), 32'd0);

    check("never_both_strobes", 32'(both_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
